alu_arbiter: RTL and testbench

- Shares one combinational ALU (32-bit operands, 6-bit opcode, OUT and ZERO outputs) between two requesters, for example the fetch/branch unit and the execute unit.
- Per operation it arbitrates round-robin, registers the ALU inputs, captures the result and ZERO flag, and returns a one-cycle DONE pulse to the winner.
- Invalid opcodes are rejected with an error flag and never reach the ALU.
- Sits between the control unit and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each operation is granted, sent to the ALU, captured, then acknowledged with a DONE pulse.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic [OPRN_WIDTH-1:0] OPRN0,
    input  logic [DATA_WIDTH-1:0] OP1_0,
    input  logic [DATA_WIDTH-1:0] OP2_0,
    input  logic                  REQ1,
    input  logic [OPRN_WIDTH-1:0] OPRN1,
    input  logic [DATA_WIDTH-1:0] OP1_1,
    input  logic [DATA_WIDTH-1:0] OP2_1,
    output logic [DATA_WIDTH-1:0] ALU_OP1,
    output logic [DATA_WIDTH-1:0] ALU_OP2,
    output logic [OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_ZERO,
    output logic [DATA_WIDTH-1:0] RES,
    output logic                  RES_ZERO,
    output logic                  ERR,
    output logic                  DONE0,
    output logic                  DONE1,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  OP_CNT,
    output logic [1:0]            DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_last;
    logic                  r_gnt;
    logic [DATA_WIDTH-1:0] r_alu_op1;
    logic [DATA_WIDTH-1:0] r_alu_op2;
    logic [OPRN_WIDTH-1:0] r_alu_oprn;
    logic [DATA_WIDTH-1:0] r_res;
    logic                  r_res_zero;
    logic                  r_err;
    logic                  r_done0;
    logic                  r_done1;
    logic [CNT_WIDTH-1:0]  r_op_cnt;

    logic                  w_grant;
    logic                  w_win;
    logic                  w_valid;
    logic [OPRN_WIDTH-1:0] w_oprn;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_op2;

    // With both requesting, the one that did not finish last wins.
    always_comb begin
        w_grant = REQ0 | REQ1;
        w_win   = (REQ0 && REQ1) ? ~r_last : REQ1;
        w_oprn  = w_win ? OPRN1 : OPRN0;
        w_op1   = w_win ? OP1_1 : OP1_0;
        w_op2   = w_win ? OP2_1 : OP2_0;
        w_valid = (w_oprn >= OPRN_WIDTH'(1)) && (w_oprn <= OPRN_WIDTH'(9));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = w_valid ? S_EXEC : S_RESP;
                end
            end
            S_EXEC:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            r_alu_op1  <= '0;
            r_alu_op2  <= '0;
            r_alu_oprn <= '0;
            r_res      <= '0;
            r_res_zero <= 1'b0;
            r_err      <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_op_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gnt <= w_win;
                        if (w_valid) begin
                            r_alu_op1  <= w_op1;
                            r_alu_op2  <= w_op2;
                            r_alu_oprn <= w_oprn;
                        end else begin
                            // Rejected opcode: ALU inputs keep their old values.
                            r_res      <= '0;
                            r_res_zero <= 1'b0;
                            r_err      <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_res      <= ALU_OUT;
                    r_res_zero <= ALU_ZERO;
                    r_err      <= 1'b0;
                end
                S_RESP: begin
                    r_done0  <= ~r_gnt;
                    r_done1  <= r_gnt;
                    r_last   <= r_gnt;
                    r_op_cnt <= r_op_cnt + CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign ALU_OP1   = r_alu_op1;
    assign ALU_OP2   = r_alu_op2;
    assign ALU_OPRN  = r_alu_oprn;
    assign RES       = r_res;
    assign RES_ZERO  = r_res_zero;
    assign ERR       = r_err;
    assign DONE0     = r_done0;
    assign DONE1     = r_done1;
    assign BUSY      = (r_state != S_IDLE);
    assign OP_CNT    = r_op_cnt;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a reference ALU model, a vector table,
// and hand-written sequences for fairness, mid-operation reset and counter wrap.
module tb_alu_arbiter;

    typedef struct packed {
        logic        req_id;
        logic [5:0]  oprn;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ0 = 1'b0, REQ1 = 1'b0;
    logic [5:0]  OPRN0 = '0, OPRN1 = '0;
    logic [31:0] OP1_0 = '0, OP2_0 = '0, OP1_1 = '0, OP2_1 = '0;
    logic [31:0] ALU_OP1, ALU_OP2, ALU_OUT, RES;
    logic [5:0]  ALU_OPRN;
    logic        ALU_ZERO, RES_ZERO, ERR, DONE0, DONE1, BUSY;
    logic [15:0] OP_CNT;
    logic [1:0]  DBG_STATE;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [51:0] exp_q[$];
    logic [15:0] model_cnt = '0;
    logic [5:0]  model_oprn = '0;
    vec_t        vecs[10];

    alu_arbiter #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .OPRN0(OPRN0), .OP1_0(OP1_0), .OP2_0(OP2_0),
        .REQ1(REQ1), .OPRN1(OPRN1), .OP1_1(OP1_1), .OP2_1(OP2_1),
        .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
        .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO),
        .RES(RES), .RES_ZERO(RES_ZERO), .ERR(ERR),
        .DONE0(DONE0), .DONE1(DONE1), .BUSY(BUSY), .OP_CNT(OP_CNT),
        .DBG_STATE(DBG_STATE)
    );

    always #5 CLK = ~CLK;

    // Reference ALU the arbiter drives.
    always_comb begin
        case (ALU_OPRN)
            6'd1:    ALU_OUT = ALU_OP1 + ALU_OP2;
            6'd2:    ALU_OUT = ALU_OP1 - ALU_OP2;
            6'd3:    ALU_OUT = ALU_OP1 * ALU_OP2;
            6'd4:    ALU_OUT = ALU_OP1 >> ALU_OP2;
            6'd5:    ALU_OUT = ALU_OP1 << ALU_OP2;
            6'd6:    ALU_OUT = ALU_OP1 & ALU_OP2;
            6'd7:    ALU_OUT = ALU_OP1 | ALU_OP2;
            6'd8:    ALU_OUT = ~(ALU_OP1 | ALU_OP2);
            6'd9:    ALU_OUT = ($signed(ALU_OP1) < $signed(ALU_OP2)) ? 32'd1 : 32'd0;
            default: ALU_OUT = 32'd0;
        endcase
        ALU_ZERO = (ALU_OUT == 32'd0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic [5:0] oprn, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            REQ1 = 1'b1; OPRN1 = oprn; OP1_1 = a; OP2_1 = b;
        end else begin
            REQ0 = 1'b1; OPRN0 = oprn; OP1_0 = a; OP2_0 = b;
        end
    endtask

    function automatic logic [51:0] mk_rec(input logic id, input logic [31:0] res,
                                           input logic zero, input logic err, input logic [15:0] cnt);
        return {(id ? 2'b10 : 2'b01), res, zero, err, cnt};
    endfunction

    // One operation from a single requester, called at a falling edge.
    task automatic run_op(input vec_t v);
        logic [51:0] exp_rec;
        int          lat;
        bit          seen;
        lat  = 0;
        seen = 0;
        if (!v.err) model_oprn = v.oprn;
        model_cnt = model_cnt + 16'd1;
        exp_q.push_back(mk_rec(v.req_id, v.res, v.zero, v.err, model_cnt));
        drive(v.req_id, v.oprn, v.op1, v.op2);
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK); @(negedge CLK);
            if (k == 1) begin
                check("busy_after_grant", 64'(BUSY), 64'd1);
                check("state_after_grant", 64'(DBG_STATE), v.err ? 64'd2 : 64'd1);
            end
            if (DONE0 || DONE1) begin
                seen = 1;
                lat  = k;
                break;
            end
        end
        exp_rec = exp_q.pop_front();
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE within 8 cycles, required one");
        end else begin
            check("latency", 64'(lat), v.err ? 64'd2 : 64'd3);
            check("result_record", 64'({DONE1, DONE0, RES, RES_ZERO, ERR, OP_CNT}), 64'(exp_rec));
            check("alu_oprn", 64'(ALU_OPRN), 64'(model_oprn));
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check("done_pulse_width", 64'({DONE1, DONE0}), 64'd0);
        check("idle_after_done", 64'(BUSY), 64'd0);
    endtask

    // Both requesters held for four operations; grants must alternate 0,1,0,1.
    task automatic run_fair();
        int          cyc;
        int          prev;
        bit          seen;
        logic [51:0] exp_rec;
        cyc  = 0;
        prev = 0;
        for (int d = 0; d < 4; d++) begin
            model_cnt = model_cnt + 16'd1;
            exp_q.push_back(mk_rec(d[0], d[0] ? 32'h0000_5678 : 32'h0F00_0F00, 1'b0, 1'b0, model_cnt));
        end
        drive(1'b0, 6'd6, 32'hFF00_FF00, 32'h0FF0_0FF0);
        drive(1'b1, 6'd6, 32'h1234_5678, 32'h0000_FFFF);
        for (int d = 0; d < 4; d++) begin
            seen = 0;
            for (int k = 1; k <= 8; k++) begin
                @(posedge CLK); @(negedge CLK);
                cyc++;
                if (DONE0 || DONE1) begin
                    seen = 1;
                    break;
                end
            end
            exp_rec = exp_q.pop_front();
            if (!seen) begin
                n_cmp++;
                n_fail++;
                $display("FAIL fair_timeout: op %0d got no DONE, required one", d);
            end else begin
                check("fair_spacing", 64'(cyc - prev), 64'd3);
                check("fair_record", 64'({DONE1, DONE0, RES, RES_ZERO, ERR, OP_CNT}), 64'(exp_rec));
            end
            prev = cyc;
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        model_oprn = 6'd6;
        @(posedge CLK); @(negedge CLK);
    endtask

    initial begin
        bit done_seen;
        vecs[0] = '{1'b0, 6'd1,  32'd5,        32'd7,        32'd12,        1'b0, 1'b0};
        vecs[1] = '{1'b1, 6'd2,  32'd9,        32'd9,        32'd0,         1'b1, 1'b0};
        vecs[2] = '{1'b0, 6'd3,  32'd6,        32'd7,        32'd42,        1'b0, 1'b0};
        vecs[3] = '{1'b1, 6'd6,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 6'd7,  32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 6'd8,  32'd0,        32'd0,        32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 6'd9,  32'd3,        32'd5,        32'd1,         1'b0, 1'b0};
        vecs[7] = '{1'b0, 6'h0A, 32'd11,       32'd22,       32'd0,         1'b0, 1'b1};
        vecs[8] = '{1'b1, 6'd0,  32'd33,       32'd44,       32'd0,         1'b0, 1'b1};
        vecs[9] = '{1'b0, 6'd5,  32'd1,        32'd4,        32'd16,        1'b0, 1'b0};

        // Reset state.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_alu_op1", 64'(ALU_OP1), 64'd0);
        check("rst_alu_op2", 64'(ALU_OP2), 64'd0);
        check("rst_alu_oprn", 64'(ALU_OPRN), 64'd0);
        check("rst_outputs", 64'({RES, RES_ZERO, ERR, DONE0, DONE1, BUSY}), 64'd0);
        check("rst_op_cnt", 64'(OP_CNT), 64'd0);
        check("rst_state", 64'(DBG_STATE), 64'd0);
        RST = 1'b0;
        @(posedge CLK); @(negedge CLK);

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Reset while in EXEC: aborted, no DONE afterwards.
        drive(1'b0, 6'd3, 32'd6, 32'd7);
        @(posedge CLK); @(negedge CLK);
        check("mid_state_exec", 64'(DBG_STATE), 64'd1);
        RST  = 1'b1;
        REQ0 = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check("mid_rst_alu", 64'({ALU_OP1, ALU_OPRN}), 64'd0);
        check("mid_rst_outputs", 64'({RES, RES_ZERO, ERR, DONE0, DONE1, BUSY}), 64'd0);
        check("mid_rst_op_cnt", 64'(OP_CNT), 64'd0);
        RST = 1'b0;
        model_cnt  = '0;
        model_oprn = '0;
        done_seen  = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); @(negedge CLK);
            if (DONE0 || DONE1) done_seen = 1;
        end
        check("no_done_after_abort", 64'(done_seen), 64'd0);

        run_fair();

        // Counter wrap from 0xFFFF.
        force dut.r_op_cnt = 16'hFFFF;
        @(posedge CLK); @(negedge CLK);
        release dut.r_op_cnt;
        @(posedge CLK); @(negedge CLK);
        check("cnt_preload", 64'(OP_CNT), 64'hFFFF);
        model_cnt = 16'hFFFF;
        run_op('{1'b0, 6'd1, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
